// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
//
// Shares one variable-latency memory port between the OTTER instruction-fetch
// requester (IF_*) and the data-memory requester (DM_*). One transaction is in
// flight at a time: the winner's attributes are registered onto M_*, the
// M_REQ/M_ACK handshake runs, and the owner's VALID pulses for one cycle while
// the FSM sits in RESP. The data side wins contested grants until STARVE_LIMIT
// consecutive contested DM grants have occurred, after which fetch wins once.
//
// Optional feature: define OTTER_ARB_TIMEOUT_EN to enable a watchdog that aborts
// a transaction after TIMEOUT_CYCLES busy cycles without M_ACK, returns a NOP
// (fetch) or zero (data), and sets the sticky ARB_ERR flag. Without the macro
// the busy states wait indefinitely and ARB_ERR is tied low.
//
// Ports:
//   CLK, RST_N                      clock (rising edge), async active-low reset
//   IF_REQ, IF_ADDR                 fetch request / word address
//   IF_RDATA, IF_VALID, IF_STALL    fetched instruction, completion pulse, stall
//   DM_REQ, DM_WE, DM_ADDR,
//   DM_WDATA, DM_BE                 data request and attributes
//   DM_RDATA, DM_VALID, DM_STALL    load data, completion pulse, stall
//   M_REQ, M_WE, M_ADDR, M_WDATA,
//   M_BE                            registered memory request
//   M_ACK, M_RDATA                  memory completion and read data
//   ARB_ERR                         sticky watchdog timeout flag
module otter_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    output logic        IF_VALID,
    output logic        IF_STALL,

    input  logic        DM_REQ,
    input  logic        DM_WE,
    input  logic [31:0] DM_ADDR,
    input  logic [31:0] DM_WDATA,
    input  logic [3:0]  DM_BE,
    output logic [31:0] DM_RDATA,
    output logic        DM_VALID,
    output logic        DM_STALL,

    output logic        M_REQ,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_BE,
    input  logic        M_ACK,
    input  logic [31:0] M_RDATA,

    output logic        ARB_ERR
);

    typedef enum logic [1:0] {
        StIdle,
        StIfBusy,
        StDmBusy,
        StResp
    } state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e     state_q;
    logic [3:0] streak_q;  // consecutive contested DM grants
    logic       grant_dm;

`ifdef OTTER_ARB_TIMEOUT_EN
    localparam int unsigned WdW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q;
    logic           arb_err_q;

    assign ARB_ERR = arb_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign ARB_ERR        = 1'b0;
`endif

    // Data wins unless fetch is also waiting and has been passed over too often.
    assign grant_dm = DM_REQ && (!IF_REQ || (streak_q != StarveMax));

    assign IF_STALL = IF_REQ & ~IF_VALID;
    assign DM_STALL = DM_REQ & ~DM_VALID;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            streak_q  <= '0;
            M_REQ     <= 1'b0;
            M_WE      <= 1'b0;
            M_ADDR    <= '0;
            M_WDATA   <= '0;
            M_BE      <= '0;
            IF_RDATA  <= '0;
            DM_RDATA  <= '0;
            IF_VALID  <= 1'b0;
            DM_VALID  <= 1'b0;
`ifdef OTTER_ARB_TIMEOUT_EN
            wd_q      <= '0;
            arb_err_q <= 1'b0;
`endif
        end else begin
            IF_VALID <= 1'b0;
            DM_VALID <= 1'b0;

            unique case (state_q)
                StIdle: begin
`ifdef OTTER_ARB_TIMEOUT_EN
                    wd_q <= '0;
`endif
                    if (grant_dm) begin
                        M_REQ   <= 1'b1;
                        M_WE    <= DM_WE;
                        M_ADDR  <= DM_ADDR;
                        M_WDATA <= DM_WDATA;
                        M_BE    <= DM_BE;
                        state_q <= StDmBusy;
                        // Only contested grants count toward starvation.
                        if (IF_REQ && (streak_q != StarveMax)) begin
                            streak_q <= streak_q + 4'd1;
                        end
                    end else if (IF_REQ) begin
                        M_REQ    <= 1'b1;
                        M_WE     <= 1'b0;
                        M_ADDR   <= IF_ADDR;
                        M_WDATA  <= '0;
                        M_BE     <= 4'hF;
                        streak_q <= '0;
                        state_q  <= StIfBusy;
                    end
                end

                StIfBusy, StDmBusy: begin
                    if (M_ACK) begin
                        M_REQ   <= 1'b0;
                        state_q <= StResp;
                        if (state_q == StIfBusy) begin
                            IF_RDATA <= M_RDATA;
                            IF_VALID <= 1'b1;
                        end else begin
                            // Stores keep the last load value.
                            if (!M_WE) begin
                                DM_RDATA <= M_RDATA;
                            end
                            DM_VALID <= 1'b1;
                        end
                    end
`ifdef OTTER_ARB_TIMEOUT_EN
                    else if (wd_q == WdLast) begin
                        // Abort: complete the owner with a harmless value.
                        M_REQ     <= 1'b0;
                        state_q   <= StResp;
                        arb_err_q <= 1'b1;
                        if (state_q == StIfBusy) begin
                            IF_RDATA <= 32'h0000_0013;
                            IF_VALID <= 1'b1;
                        end else begin
                            DM_RDATA <= 32'h0000_0000;
                            DM_VALID <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end

                // VALID is high during this cycle; no arbitration here.
                StResp: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
